// File: rtl/alsu_pipe.sv
// Handshaked, parametrised ALSU. One request per valid/ready transfer. Multiply is a
// WIDTH-cycle shift-add. Shift/rotate act on the held result. Invalid requests flag err.
module alsu_pipe #(
    parameter int WIDTH          = 4,
    parameter     INPUT_PRIORITY = "A",
    parameter bit FULL_ADDER     = 1'b1,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    input  logic [2:0]             opcode,
    input  logic                   cin,
    input  logic                   serial_in,
    input  logic                   direction,
    input  logic                   red_op_A,
    input  logic                   red_op_B,
    input  logic                   bypass_A,
    input  logic                   bypass_B,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out,
    output logic                   err,
    output logic [15:0]            leds,
    output logic [ERR_CNT_W-1:0]   err_cnt
);
    localparam int RW    = 2 * WIDTH;
    localparam int CW    = $clog2(WIDTH);
    localparam bit PRI_A = (INPUT_PRIORITY == "A");

    typedef enum logic [1:0] {IDLE, EXEC, MUL, HOLD} state_t;
    state_t state;

    logic [WIDTH-1:0] A_r, B_r;
    logic [2:0]       opcode_r;
    logic             cin_r, serial_in_r, direction_r;
    logic             red_op_A_r, red_op_B_r, bypass_A_r, bypass_B_r;

    logic [RW-1:0]    mcand, acc;
    logic [WIDTH-1:0] mplier;
    logic             neg;
    logic [CW-1:0]    cnt;

    logic [RW-1:0]    a_x, b_x, a_abs, alu_res, byp_opnd, acc_nxt;
    logic [WIDTH-1:0] b_abs, red_opnd;
    logic             invalid, bypass, red, is_mul;

    assign in_ready = (state == IDLE) && rst;

    assign a_x     = {{WIDTH{A_r[WIDTH-1]}}, A_r};
    assign b_x     = {{WIDTH{B_r[WIDTH-1]}}, B_r};
    assign a_abs   = a_x[RW-1] ? -a_x : a_x;
    assign b_abs   = B_r[WIDTH-1] ? -B_r : B_r;
    assign bypass  = bypass_A_r || bypass_B_r;
    assign red     = red_op_A_r || red_op_B_r;
    assign invalid = (red && (opcode_r >= 3'd2)) || (opcode_r >= 3'd6);
    assign is_mul  = (opcode_r == 3'd3) && !bypass;
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    assign byp_opnd = (bypass_A_r && bypass_B_r) ? (PRI_A ? a_x : b_x)
                    : (bypass_A_r ? a_x : b_x);
    assign red_opnd = (red_op_A_r && red_op_B_r) ? (PRI_A ? A_r : B_r)
                    : (red_op_A_r ? A_r : B_r);

    always_comb begin
        alu_res = '0;
        if (bypass) begin
            alu_res = byp_opnd;
        end else begin
            case (opcode_r)
                3'd0: alu_res = red ? {{(RW-1){1'b0}}, |red_opnd} : (a_x | b_x);
                3'd1: alu_res = red ? {{(RW-1){1'b0}}, ^red_opnd} : (a_x ^ b_x);
                3'd2: alu_res = a_x + b_x + {{(RW-1){1'b0}}, FULL_ADDER & cin_r};
                3'd4: alu_res = direction_r ? {out[RW-2:0], serial_in_r}
                                            : {serial_in_r, out[RW-1:1]};
                3'd5: alu_res = direction_r ? {out[RW-2:0], out[RW-1]}
                                            : {out[0], out[RW-1:1]};
                default: alu_res = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            out         <= '0;
            out_valid   <= 1'b0;
            err         <= 1'b0;
            leds        <= '0;
            err_cnt     <= '0;
            A_r         <= '0;
            B_r         <= '0;
            opcode_r    <= '0;
            cin_r       <= 1'b0;
            serial_in_r <= 1'b0;
            direction_r <= 1'b0;
            red_op_A_r  <= 1'b0;
            red_op_B_r  <= 1'b0;
            bypass_A_r  <= 1'b0;
            bypass_B_r  <= 1'b0;
            mcand       <= '0;
            acc         <= '0;
            mplier      <= '0;
            neg         <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    A_r         <= A;
                    B_r         <= B;
                    opcode_r    <= opcode;
                    cin_r       <= cin;
                    serial_in_r <= serial_in;
                    direction_r <= direction;
                    red_op_A_r  <= red_op_A;
                    red_op_B_r  <= red_op_B;
                    bypass_A_r  <= bypass_A;
                    bypass_B_r  <= bypass_B;
                    state       <= EXEC;
                end
                EXEC: begin
                    if (invalid) begin
                        out       <= '0;
                        err       <= 1'b1;
                        leds      <= ~leds;
                        if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (is_mul) begin
                        // out is left untouched until the product is final
                        err    <= 1'b0;
                        leds   <= '0;
                        mcand  <= a_abs;
                        mplier <= b_abs;
                        acc    <= '0;
                        neg    <= A_r[WIDTH-1] ^ B_r[WIDTH-1];
                        cnt    <= '0;
                        state  <= MUL;
                    end else begin
                        out       <= alu_res;
                        err       <= 1'b0;
                        leds      <= '0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= {mcand[RW-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) begin
                        out       <= neg ? -acc_nxt : acc_nxt;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alsu_pipe.sv
// Randomised scoreboard bench for alsu_pipe: the driver pushes reference results computed
// with integer arithmetic, and a monitor pops and compares them as results appear.
module tb_alsu_pipe;
    localparam int W  = 4;
    localparam int RW = 2 * W;

    typedef struct {
        logic [W-1:0] a, b;
        logic [2:0]   op;
        logic         cin, sin, dir, ra, rb, ba, bb;
    } req_t;

    typedef struct {
        logic [RW-1:0] out;
        logic          err;
        logic [15:0]   leds;
        int            cnt;
        int            lat;
        int            acc;
    } exp_t;

    logic clk = 1'b0, rst = 1'b0;
    logic in_valid = 1'b0, out_ready;
    logic in_ready, out_valid, err;
    logic [W-1:0] A = '0, B = '0;
    logic [2:0] opcode = '0;
    logic cin = 0, serial_in = 0, direction = 0, red_op_A = 0, red_op_B = 0, bypass_A = 0, bypass_B = 0;
    logic [RW-1:0] out;
    logic [15:0] leds;
    logic [7:0] err_cnt;

    alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY("A"), .FULL_ADDER(1'b1), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .opcode(opcode), .cin(cin), .serial_in(serial_in), .direction(direction),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .err(err), .leds(leds),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    exp_t exp_q[$];
    logic bp = 1'b0;
    logic [RW-1:0] m_out = '0;
    logic [15:0]   m_leds = '0;
    int            m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: integer arithmetic on the signed operand values. Latency is counted in
    // edges after the accepting edge: 1 for single-cycle ops, W+1 for multiply.
    task automatic model(input req_t r, output exp_t e);
        int sa, sb, res;
        logic [W-1:0] sel;
        sa = $signed(r.a);
        sb = $signed(r.b);
        res = 0;
        e.lat = 1;
        e.acc = 0;
        if (r.op >= 6 || ((r.ra || r.rb) && r.op >= 2)) begin
            e.out = '0;
            e.err = 1'b1;
            m_leds = ~m_leds;
            if (m_cnt < 255) m_cnt++;
        end else begin
            e.err = 1'b0;
            m_leds = '0;
            sel = r.ra ? r.a : r.b;
            if (r.ba) res = sa;
            else if (r.bb) res = sb;
            else case (r.op)
                3'd0: res = (r.ra || r.rb) ? int'(|sel) : (sa | sb);
                3'd1: res = (r.ra || r.rb) ? int'(^sel) : (sa ^ sb);
                3'd2: res = sa + sb + int'(r.cin);
                3'd3: begin res = sa * sb; e.lat = W + 1; end
                3'd4: res = r.dir ? ((int'(m_out) << 1) | int'(r.sin))
                                  : ((int'(r.sin) << (RW-1)) | (int'(m_out) >> 1));
                default: res = r.dir ? ((int'(m_out) << 1) | int'(m_out[RW-1]))
                                     : ((int'(m_out[0]) << (RW-1)) | (int'(m_out) >> 1));
            endcase
            e.out = res[RW-1:0];
        end
        m_out  = e.out;
        e.leds = m_leds;
        e.cnt  = m_cnt;
    endtask

    function automatic req_t mk(input int a, input int b, input int op, input bit c, input bit s, input bit d);
        req_t r;
        r.a = a[W-1:0]; r.b = b[W-1:0]; r.op = op[2:0];
        r.cin = c; r.sin = s; r.dir = d;
        r.ra = 0; r.rb = 0; r.ba = 0; r.bb = 0;
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r = mk(int'($urandom), int'($urandom), int'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom), 1'($urandom));
        r.ra = ($urandom_range(0, 4) == 0);
        r.rb = ($urandom_range(0, 4) == 0);
        r.ba = ($urandom_range(0, 6) == 0);
        r.bb = ($urandom_range(0, 6) == 0);
        return r;
    endfunction

    task automatic drive(input req_t r);
        A = r.a; B = r.b; opcode = r.op; cin = r.cin; serial_in = r.sin; direction = r.dir;
        red_op_A = r.ra; red_op_B = r.rb; bypass_A = r.ba; bypass_B = r.bb;
    endtask

    task automatic send(input req_t r);
        exp_t e;
        int t;
        t = 0;
        @(negedge clk);
        drive(r);
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            model(r, e);
            e.acc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 300) begin @(negedge clk); t++; end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            out_ready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pop on each new result, then hold out/err to that entry while valid.
    initial begin
        exp_t cur;
        logic pv, have;
        pv = 1'b0;
        have = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv = 1'b0;
                have = 1'b0;
            end else if (out_valid) begin
                if (!pv) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 32'd1, 32'd0);
                        have = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                        have = 1'b1;
                        chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                        chk("leds", 32'(leds), 32'(cur.leds));
                        chk("err_cnt", 32'(err_cnt), 32'(cur.cnt));
                    end
                end
                if (have) begin
                    chk("out", 32'(out), 32'(cur.out));
                    chk("err", 32'(err), 32'(cur.err));
                end
            end
            pv = out_valid;
        end
    end

    initial begin
        req_t r;
        int t;
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // shift from reset value, add, then the shift/rotate chain through 8'h81
        send(mk(0, 0, 4, 0, 1, 1));
        send(mk(7, 7, 2, 1, 0, 0));
        send(mk(1, 0, 2, 0, 0, 0));
        send(mk(0, 0, 4, 0, 1, 1));
        send(mk(0, 0, 4, 0, 1, 0));
        send(mk(0, 0, 5, 0, 0, 1));
        send(mk(0, 0, 4, 0, 1, 0));

        send(mk(-8, 7, 3, 0, 0, 0));
        repeat (W + 1) begin @(negedge clk); chk("mul_in_ready", 32'(in_ready), 32'd0); end
        send(mk(-3, -5, 3, 0, 0, 0));
        send(mk(0, 0, 6, 0, 0, 0));
        send(mk(0, 0, 6, 0, 0, 0));
        send(mk(1, 2, 0, 0, 0, 0));
        r = mk(5, 2, 1, 0, 0, 0); r.ra = 1; r.rb = 1; send(r);
        r = mk(-8, 3, 3, 0, 0, 0); r.ba = 1; r.bb = 1; send(r);
        drain();

        // backpressure: result must stay put and a competing request must be ignored
        bp = 1'b1;
        send(mk(3, 2, 2, 0, 0, 0));
        t = 0;
        while (!out_valid && t < 20) begin @(negedge clk); t++; end
        chk("bp_valid_seen", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            drive(mk(6, 1, 0, 0, 0, 0));
            in_valid = 1'b1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        bp = 1'b0;
        drain();

        // reset two cycles into a multiply
        send(mk(5, 3, 3, 0, 0, 0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_out", 32'(out), 32'd0);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        chk("mrst_leds", 32'(leds), 32'd0);
        chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        m_out = '0; m_leds = '0; m_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_idle_ready", 32'(in_ready), 32'd1);
        chk("mrst_no_result", 32'(out_valid), 32'd0);
        send(mk(0, 0, 4, 0, 1, 1));
        drain();

        // saturate the error counter
        repeat (260) begin
            r = rnd_req();
            r.ba = 0; r.bb = 0;
            if ($urandom_range(0, 1) == 0) r.op = 3'($urandom_range(6, 7));
            else begin r.op = 3'($urandom_range(2, 7)); r.ra = 1; end
            send(r);
        end
        drain();

        repeat (300) send(rnd_req());
        drain();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
